add_1: RTL and testbench

Registered n-bit incrementer: it adds the constant 1 to an unsigned n-bit operand and presents the (n+1)-bit result, including carry-out, one clock later. It is a leaf arithmetic block used wherever a counter, pointer or address needs a +1 step with explicit overflow visibility. The +1 is built as a half-adder ripple chain with a carry-in tied to 1, not an inferred `+` operator, so the carry path is explicit and inspectable.

---
 rtl/add_1.sv | 46 ++++
 tb/tb_add_1.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/add_1.sv
// Registered n-bit incrementer built as an explicit half-adder ripple chain.
// S = X + 1, with the carry-out in S[n], shown one clock after in_valid.
module add_1 #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [n-1:0] X,
    input  logic         in_valid,
    output logic [n:0]   S,
    output logic         out_valid,
    output logic         ovf
);

    logic [n:0]   c;
    logic [n-1:0] sum;

    // Half-adder chain with the carry-in tied to 1, so the +1 carry path stays visible.
    always_comb begin
        // NOTE: give every always_comb output a default first so that no path can infer a latch.
        c   = '0;
        sum = '0;
        c[0] = 1'b1;
        for (int i = 0; i < n; i++) begin
            sum[i]   = X[i] ^ c[i];
            c[i + 1] = X[i] & c[i];
        end
    end

    // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S         <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            // When in_valid is low S and ovf hold, so a stray X/Z operand never reaches them.
            if (in_valid) begin
                S   <= {c[n], sum};
                ovf <= c[n];
            end
        end
    end

endmodule

// File: tb/tb_add_1.sv
// Self-checking bench for add_1: scoreboard of expected results, checked one cycle
// after each accepted operand, for the n = 8 and n = 1 instances.
module tb_add_1;

    typedef struct {
        logic [8:0] s;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] x8;
    logic       in_valid8;
    logic [8:0] s8;
    logic       out_valid8;
    logic       ovf8;
    logic [0:0] x1;
    logic       in_valid1;
    logic [1:0] s1;
    logic       out_valid1;
    logic       ovf1;

    int   n_compared   = 0;
    int   n_mismatched = 0;
    exp_t sb[$];
    logic [8:0] last_s;

    add_1 #(.n(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .X         (x8),
        .in_valid  (in_valid8),
        .S         (s8),
        .out_valid (out_valid8),
        .ovf       (ovf8)
    );

    add_1 #(.n(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .X         (x1),
        .in_valid  (in_valid1),
        .S         (s1),
        .out_valid (out_valid1),
        .ovf       (ovf1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        n_compared++;
        assert (observed === expected)
        else begin
            n_mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of the n = 8 instance and checks what it shows after that edge.
    task automatic step8(input logic v, input logic [7:0] x, input string tag);
        exp_t e;
        @(negedge clk);
        in_valid8 = v;
        x8        = v ? x : 8'bx;
        if (v) begin
            e.s   = 9'(x) + 9'd1;
            e.ovf = (x == 8'hFF);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (v) begin
            e = sb.pop_front();
            check({tag, ".valid"}, 16'(out_valid8), 16'd1);
            check({tag, ".S"},     16'(s8),         16'(e.s));
            check({tag, ".ovf"},   16'(ovf8),       16'(e.ovf));
            last_s = e.s;
        end else begin
            check({tag, ".idle_valid"}, 16'(out_valid8), 16'd0);
            check({tag, ".hold_S"},     16'(s8),         16'(last_s));
        end
    endtask

    initial begin
        rst_n     = 1'b1;
        in_valid8 = 1'b0;
        x8        = 8'bx;
        in_valid1 = 1'b0;
        x1        = 1'b0;
        last_s    = 9'h000;

        // Give the outputs a nonzero value first so reset visibly clears them.
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        step8(1'b1, 8'h41, "pre_reset");

        // Asynchronous reset mid-cycle, checked before any clock edge.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst.S",     16'(s8),         16'h000);
        check("rst.ovf",   16'(ovf8),       16'd0);
        check("rst.valid", 16'(out_valid8), 16'd0);

        // Inputs are ignored while reset is held low.
        in_valid8 = 1'b1;
        x8        = 8'hFF;
        @(posedge clk);
        #1;
        check("rst_hold.S",     16'(s8),         16'h000);
        check("rst_hold.valid", 16'(out_valid8), 16'd0);
        @(negedge clk);
        in_valid8 = 1'b0;
        x8        = 8'bx;
        rst_n     = 1'b1;
        last_s    = 9'h000;

        step8(1'b0, 8'h00, "post_release0");
        step8(1'b0, 8'h00, "post_release1");
        check("post_release.ovf", 16'(ovf8), 16'd0);

        step8(1'b1, 8'h6E, "typical");
        step8(1'b1, 8'hFF, "full_carry");
        step8(1'b1, 8'h00, "zero");

        step8(1'b1, 8'h6E, "stream0");
        step8(1'b1, 8'hFF, "stream1");
        step8(1'b1, 8'h00, "stream2");
        step8(1'b0, 8'h00, "idle0");
        step8(1'b0, 8'h00, "idle1");

        for (int i = 0; i < 256; i++) begin
            step8(1'b1, 8'(i), $sformatf("exh%0d", i));
        end

        // Reset with a result in flight: out_valid must drop at once.
        step8(1'b1, 8'h12, "pre_midrst");
        @(negedge clk);
        in_valid8 = 1'b1;
        x8        = 8'h34;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst.valid", 16'(out_valid8), 16'd0);
        check("midrst.S",     16'(s8),         16'h000);
        @(posedge clk);
        #1;
        check("midrst_edge.valid", 16'(out_valid8), 16'd0);
        @(negedge clk);
        in_valid8 = 1'b0;
        x8        = 8'bx;
        rst_n     = 1'b1;

        // n = 1 instance.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid1 = 1'b1;
            x1        = 1'(i);
            @(posedge clk);
            #1;
            check($sformatf("n1_x%0d.S", i),     16'(s1),         16'(i + 1));
            check($sformatf("n1_x%0d.ovf", i),   16'(ovf1),       16'(i));
            check($sformatf("n1_x%0d.valid", i), 16'(out_valid1), 16'd1);
        end
        @(negedge clk);
        in_valid1 = 1'b0;

        check("sb_drained", 16'(sb.size()), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
